// File: rtl/trail_pkg.sv
// Shared types, geometry and colour constants for the trail compositor.
// Also holds the address and pixel-slot helpers used by the pipeline.
package trail_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int PIX_BITS     = 4;
  localparam int PIX_PER_WORD = 2;
  localparam int WORD_W       = 16;
  localparam int N_PLAYERS    = 2;

  localparam int PIX_STRIDE = WORD_W / PIX_PER_WORD;
  localparam int SLOT_W     = $clog2(PIX_PER_WORD);
  localparam int N_VALUES   = 1 << PIX_BITS;
  localparam int ROW_WORDS  = H_RES / PIX_PER_WORD;
  localparam int ADDR_W     = $clog2(H_RES * V_RES / PIX_PER_WORD);

  typedef logic [PIX_BITS-1:0] color_t;

  localparam color_t TRANSPARENT = 4'hF;
  localparam color_t BG_COLOR    = 4'h8;

  localparam logic [N_PLAYERS*N_VALUES-1:0] COLL_MASK = 32'h4010_4040;

  // Row start address as a sum of shifted copies of y, one per set bit of ROW_WORDS.
  function automatic logic [ADDR_W-1:0] row_base(input logic [9:0] y);
    logic [ADDR_W-1:0] sum;
    sum = {ADDR_W{1'b0}};
    for (int b = 0; b < ADDR_W; b++) begin
      sum = sum + (ROW_WORDS[b] ? (ADDR_W'(y) << b) : {ADDR_W{1'b0}});
    end
    return sum;
  endfunction

  function automatic color_t trail_of(input logic [WORD_W-1:0] word,
                                      input logic [SLOT_W-1:0] slot);
    return color_t'(word >> (PIX_STRIDE * int'(slot)));
  endfunction

endpackage

// File: rtl/trail_compositor_if.sv
// Scan-position, frame-buffer read port and composited-pixel signals.
// The compositor is the slave; the scan/RAM/colour-mapper side is the master.
interface trail_compositor_if;
  import trail_pkg::*;

  logic [9:0]                    DrawX;
  logic [9:0]                    DrawY;
  logic [N_PLAYERS*PIX_BITS-1:0] sprite_color;
  logic [ADDR_W-1:0]             rd_addr;
  logic [WORD_W-1:0]             rd_data;
  color_t                        color_enum;
  logic [N_PLAYERS-1:0]          collide;
  logic                          frame_done;

  modport master (
    output DrawX, DrawY, sprite_color, rd_data,
    input  rd_addr, color_enum, collide, frame_done
  );

  modport slave (
    input  DrawX, DrawY, sprite_color, rd_data,
    output rd_addr, color_enum, collide, frame_done
  );
endinterface

// File: rtl/frame_edge_sync.sv
// Two-flop synchroniser for the asynchronous frame tick plus a rising-edge pulse.
// Edges are suppressed until the chain holds post-reset samples, so a tick already high at release is ignored.
module frame_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic [2:0] sync_q, sync_d;
  logic [1:0] warm_q, warm_d;

  // Shift the synchroniser chain and count cycles since reset up to 3
  always_comb begin
    sync_d = {sync_q[1:0], async_i};
    if (warm_q != 2'd3) begin
      warm_d = warm_q + 2'd1;
    end else begin
      warm_d = warm_q;
    end
  end

  // Synchroniser and warm-up registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
      warm_q <= 2'd0;
    end else begin
      sync_q <= sync_d;
      warm_q <= warm_d;
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2] & (warm_q == 2'd3);

endmodule

// File: rtl/trail_compositor.sv
// Two-stage per-pixel compositor: frame-buffer fetch, sprite overlay with
// lowest-index priority, and per-player sticky collision flags published per frame.
module trail_compositor
  import trail_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  trail_compositor_if.slave bus
);

  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic                          valid_q, valid_d;
  logic [N_PLAYERS*PIX_BITS-1:0] sprite_q, sprite_d;
  color_t                        color_q, color_d;
  logic [N_PLAYERS-1:0]          acc_q, acc_d;
  logic [N_PLAYERS-1:0]          collide_q, collide_d;
  logic                          done_q, done_d;

  logic                          on_screen_s;
  color_t                        trail_s;
  logic [N_PLAYERS-1:0]          det_s;
  logic                          edge_s;

  frame_edge_sync u_edge (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .async_i (frame_clk),
    .pulse_o (edge_s)
  );

  // Stage 1: packed word address and slot; off-screen pixels read word 0 and are invalid
  always_comb begin
    on_screen_s = (bus.DrawX < 10'(H_RES)) && (bus.DrawY < 10'(V_RES));
    slot_d      = bus.DrawX[SLOT_W-1:0];
    valid_d     = on_screen_s;
    sprite_d    = bus.sprite_color;
    if (on_screen_s) begin
      addr_d = ADDR_W'(bus.DrawX >> SLOT_W) + row_base(bus.DrawY);
    end else begin
      addr_d = {ADDR_W{1'b0}};
    end
  end

  // Stage 2: overlay (scan from highest index so player 0 wins) and per-player hit tests
  always_comb begin
    trail_s = trail_of(bus.rd_data, slot_q);
    color_d = trail_s;
    det_s   = {N_PLAYERS{1'b0}};
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (sprite_q[p*PIX_BITS +: PIX_BITS] != TRANSPARENT) begin
        color_d  = sprite_q[p*PIX_BITS +: PIX_BITS];
        det_s[p] = valid_q & COLL_MASK[p*N_VALUES + int'(trail_s)];
      end else begin
        det_s[p] = 1'b0;
      end
    end
    if (!valid_q) begin
      color_d = BG_COLOR;
    end else begin
      color_d = color_d;
    end
  end

  // Frame boundary: publish the finished frame and restart from this cycle's hits
  always_comb begin
    done_d = edge_s;
    if (edge_s) begin
      collide_d = acc_q;
      acc_d     = det_s;
    end else begin
      collide_d = collide_q;
      acc_d     = acc_q | det_s;
    end
  end

  // Pipeline, accumulator and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q    <= {ADDR_W{1'b0}};
      slot_q    <= {SLOT_W{1'b0}};
      valid_q   <= 1'b0;
      sprite_q  <= {N_PLAYERS{TRANSPARENT}};
      color_q   <= BG_COLOR;
      acc_q     <= {N_PLAYERS{1'b0}};
      collide_q <= {N_PLAYERS{1'b0}};
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      sprite_q  <= sprite_d;
      color_q   <= color_d;
      acc_q     <= acc_d;
      collide_q <= collide_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_addr    = addr_q;
  assign bus.color_enum = color_q;
  assign bus.collide    = collide_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_trail_compositor.sv
// Randomised and directed bench for trail_compositor against a pixel-level reference model.
module tb_trail_compositor;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  spr;
    bit          ovr;
    logic [15:0] w;
  } pix_t;

  localparam logic [31:0] MASK_TB = 32'h4010_4040;

  logic Clk;
  logic Reset;
  logic frame_clk;

  trail_compositor_if vif ();

  trail_compositor dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (vif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int   n_chk = 0;
  int   n_bad = 0;
  pix_t prev_p;
  pix_t idle_p;
  logic [1:0] acc_m;
  logic [1:0] col_m;
  bit   done_m;
  int   edge_cd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input logic [7:0] spr,
                              input bit ovr, input logic [15:0] w);
    pix_t p;
    p.x = x; p.y = y; p.spr = spr; p.ovr = ovr; p.w = w;
    return p;
  endfunction

  function automatic bit on_screen(input pix_t p);
    return (p.x < 640) && (p.y < 480);
  endfunction

  function automatic int addr_of(input pix_t p);
    if (!on_screen(p)) return 0;
    return p.x / 2 + p.y * 320;
  endfunction

  function automatic logic [15:0] ram_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    return h[27:12] ^ h[15:0];
  endfunction

  function automatic logic [3:0] trail_pix(input pix_t p, input logic [15:0] w);
    logic [15:0] sh;
    sh = w >> (8 * (p.x % 2));
    return sh[3:0];
  endfunction

  function automatic logic [3:0] exp_color(input pix_t p, input logic [15:0] w);
    logic [7:0] s;
    if (!on_screen(p)) return 4'h8;
    for (int q = 0; q < 2; q++) begin
      s = p.spr >> (4 * q);
      if (s[3:0] != 4'hF) return s[3:0];
    end
    return trail_pix(p, w);
  endfunction

  function automatic logic [1:0] exp_det(input pix_t p, input logic [15:0] w);
    logic [1:0]  r;
    logic [7:0]  s;
    logic [31:0] m;
    int          t;
    r = 2'b00;
    m = MASK_TB;
    if (!on_screen(p)) return r;
    t = int'(trail_pix(p, w));
    for (int q = 0; q < 2; q++) begin
      s = p.spr >> (4 * q);
      if (s[3:0] != 4'hF && m[q * 16 + t]) r[q] = 1'b1;
    end
    return r;
  endfunction

  // One clock: apply p, advance the model by one pixel, then compare all outputs.
  task automatic step(input pix_t p);
    logic [15:0] wp;
    logic [1:0]  d;
    int          ea;
    logic [3:0]  ec;
    bit          fire;
    vif.DrawX        = 10'(p.x);
    vif.DrawY        = 10'(p.y);
    vif.sprite_color = p.spr;
    @(posedge Clk);
    wp = prev_p.ovr ? prev_p.w : ram_word(32'(addr_of(prev_p)));
    if (Reset) begin
      acc_m = 2'b00; col_m = 2'b00; done_m = 1'b0; edge_cd = 0;
      ec = 4'h8; ea = 0; prev_p = idle_p;
    end else begin
      ec   = exp_color(prev_p, wp);
      d    = exp_det(prev_p, wp);
      fire = 1'b0;
      if (edge_cd > 0) begin
        edge_cd--;
        fire = (edge_cd == 0);
      end
      done_m = fire;
      if (fire) begin
        col_m = acc_m;
        acc_m = d;
      end else begin
        acc_m = acc_m | d;
      end
      ea     = addr_of(p);
      prev_p = p;
    end
    #1;
    vif.rd_data = prev_p.ovr ? prev_p.w : ram_word(32'(vif.rd_addr));
    chk("rd_addr",    32'(vif.rd_addr),    32'(ea));
    chk("color_enum", 32'(vif.color_enum), 32'(ec));
    chk("frame_done", 32'(vif.frame_done), 32'(done_m));
    chk("collide",    32'(vif.collide),    32'(col_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(idle_p);
  endtask

  task automatic raise_frame();
    frame_clk = 1'b1;
    edge_cd   = 3;
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    int   r;
    logic [3:0] v;
    p.x = ($urandom_range(0, 15) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
    p.y = ($urandom_range(0, 15) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
    p.ovr = 1'b0;
    p.w   = 16'h0000;
    p.spr = 8'hFF;
    for (int q = 0; q < 2; q++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        2:       v = (($urandom_range(0, 2) == 0) ? 4'h4 : (($urandom_range(0, 1) == 0) ? 4'h6 : 4'hE));
        3:       v = 4'($urandom_range(0, 15));
        default: v = 4'hF;
      endcase
      p.spr[4*q +: 4] = v;
    end
    return p;
  endfunction

  initial begin
    int hi_left;
    int lo_left;
    idle_p = mk(1023, 1023, 8'hFF, 1'b0, 16'h0000);
    prev_p = idle_p;
    acc_m = 2'b00; col_m = 2'b00; done_m = 1'b0; edge_cd = 0;
    Reset = 1'b1; frame_clk = 1'b0;
    vif.rd_data = 16'h0000;

    step(idle_p); step(idle_p);
    Reset = 1'b0;
    idle(4);

    // Pixel fetch
    step(mk(5, 2, 8'hFF, 1'b1, 16'h0A03));
    chk("addr_642", 32'(vif.rd_addr), 32'd642);
    step(mk(4, 2, 8'hFF, 1'b1, 16'h0A03));
    chk("fetch_x5", 32'(vif.color_enum), 32'hA);
    step(idle_p);
    chk("fetch_x4", 32'(vif.color_enum), 32'h3);

    // Sprite priority
    step(mk(10, 10, 8'h46, 1'b1, 16'h8888));
    step(mk(10, 10, 8'h4F, 1'b1, 16'h8888));
    chk("prio_p0", 32'(vif.color_enum), 32'h6);
    step(idle_p);
    chk("prio_p1", 32'(vif.color_enum), 32'h4);
    idle(2);
    raise_frame(); idle(6); frame_clk = 1'b0; idle(4);

    // Collision published, then cleared by an empty frame
    step(mk(20, 20, 8'hF6, 1'b1, 16'hEEEE));
    idle(3);
    raise_frame(); idle(6);
    chk("coll_pub", 32'(vif.collide), 32'h1);
    frame_clk = 1'b0; idle(4);
    raise_frame(); idle(6);
    chk("coll_clear", 32'(vif.collide), 32'h0);
    frame_clk = 1'b0; idle(4);

    // Off-screen pixel over a lethal word
    step(mk(700, 20, 8'hF6, 1'b1, 16'hEEEE));
    step(idle_p);
    chk("offscreen_bg", 32'(vif.color_enum), 32'h8);
    idle(2);
    raise_frame(); idle(6);
    chk("offscreen_nocoll", 32'(vif.collide), 32'h0);
    frame_clk = 1'b0; idle(4);

    // Detection on the edge cycle goes to the new frame
    raise_frame();
    step(idle_p);
    step(mk(40, 40, 8'hF6, 1'b1, 16'hEEEE));
    step(idle_p);
    chk("coinc_done", 32'(vif.frame_done), 32'h1);
    chk("coinc_excl", 32'(vif.collide), 32'h0);
    idle(4); frame_clk = 1'b0; idle(4);
    raise_frame(); idle(6);
    chk("coinc_next", 32'(vif.collide), 32'h1);
    frame_clk = 1'b0; idle(4);

    // Reset mid-frame drops the partial accumulation
    step(mk(30, 30, 8'h4F, 1'b1, 16'h4444));
    idle(2);
    Reset = 1'b1; step(idle_p); Reset = 1'b0;
    chk("rst_collide", 32'(vif.collide), 32'h0);
    idle(5);
    raise_frame(); idle(6);
    chk("rst_pub", 32'(vif.collide), 32'h0);
    frame_clk = 1'b0; idle(4);

    // Frame tick already high at reset release produces no edge
    frame_clk = 1'b1;
    Reset = 1'b1; step(idle_p); Reset = 1'b0;
    idle(8);
    frame_clk = 1'b0; idle(6);

    // Randomised traffic with random frame ticks and occasional resets
    lo_left = 40;
    hi_left = 0;
    for (int i = 0; i < 3000; i++) begin
      step(rand_pix());
      if (frame_clk) begin
        hi_left--;
        if (hi_left == 0) begin
          frame_clk = 1'b0;
          lo_left   = int'($urandom_range(20, 150));
        end
      end else begin
        lo_left--;
        if (lo_left == 0) begin
          raise_frame();
          hi_left = int'($urandom_range(4, 12));
        end else if (lo_left > 12 && $urandom_range(0, 399) == 0) begin
          Reset = 1'b1; step(rand_pix()); Reset = 1'b0;
        end
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
